qam_tx_sched: RTL and testbench
===============================

QAM_TX_SCHED -- requirements
Module: qam_tx_sched

Interface
REQ-001 Parameter SYM_DIV, default 200: carrier cycles per symbol period (4 bits x 50 carrier cycles per bit); legal range 8..255.
REQ-002 Parameter PREAMBLE_LEN, default 8: preamble symbols per frame; legal range 1..255.
REQ-003 Parameter FRAME_LEN, default 32: payload symbols per frame; legal range 1..255.
REQ-004 Parameter GAP_LEN, default 4: idle symbols after each frame; legal range 1..255.
REQ-005 Ports, one per line:
- clk_carrier  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to send a frame.
- bit_in  in  1  serial payload bit.
- bit_valid  in  1  bit_in is valid.
- bit_ready  out  1  block accepts bit_in this cycle.
- sym_i  out  2  in-phase symbol to the 16QAM modulator.
- sym_q  out  2  quadrature symbol to the 16QAM modulator.
- sym_stb  out  1  one-cycle pulse: new symbol valid.
- count_num  out  8  symbol-period counter.
- busy  out  1  state is not IDLE.
- underrun  out  1  one-cycle pulse: pad symbol inserted.

Function
REQ-006 The FSM SHALL use states IDLE, PREAMBLE, PAYLOAD and GAP.
- IDLE -> PREAMBLE on start.
- PREAMBLE -> PAYLOAD after PREAMBLE_LEN symbols.
- PAYLOAD -> GAP after FRAME_LEN symbols.
- GAP -> PREAMBLE after GAP_LEN symbols if start_pending is set; otherwise GAP -> IDLE.
REQ-007 count_num SHALL be 0 in IDLE, SHALL be 0 on the cycle after entry to PREAMBLE from IDLE, and SHALL count 0..SYM_DIV-1, wrapping to 0, in every other state.
REQ-008 A symbol tick SHALL occur when count_num equals SYM_DIV-1; on that edge sym_i/sym_q SHALL update and sym_stb SHALL be high for exactly the following cycle.
REQ-009 Preamble symbol k SHALL be {11,11} for even k and {00,00} for odd k (sym_i,sym_q), with k starting at 0.
REQ-010 A 4-bit assembly buffer with an occupancy count 0..4 SHALL collect bits; the first accepted bit is sym_i[1], then sym_i[0], sym_q[1], sym_q[0].
REQ-011 bit_ready SHALL be high iff state is PREAMBLE or PAYLOAD and occupancy < 4; a bit is accepted when bit_valid and bit_ready are both high.
REQ-012 On a PAYLOAD tick with occupancy 4, the tick SHALL emit the buffer and set occupancy to 0; if a bit is accepted on the same cycle, occupancy SHALL become 1 holding that bit.
REQ-013 On a PAYLOAD tick with occupancy < 4:
- emit pad symbol {01,01};
- pulse underrun;
- keep partial buffer contents;
- still count the symbol toward FRAME_LEN.
REQ-014 In GAP, ticks SHALL emit {01,01} with sym_stb; any partial buffer SHALL be discarded on entry to GAP.
REQ-015 start while busy SHALL set start_pending; start_pending is consumed at the GAP exit decision; multiple starts SHALL collapse to one.
REQ-016 start and the final GAP tick in the same cycle SHALL take the GAP -> PREAMBLE transition.

Reset
REQ-017 Reset SHALL force all outputs and internal state to 0: state IDLE, count_num 0, sym_i/sym_q 00, sym_stb 0, underrun 0, bit_ready 0, busy 0, occupancy 0, start_pending 0.
REQ-018 Reset mid-frame SHALL abort immediately with no further sym_stb.

Configuration
REQ-019 With QAM_TX_SCRAMBLE_EN defined, each accepted payload bit SHALL be XORed with an x^7+x^6+1 LFSR seeded to 7'h7F at each PREAMBLE entry, advancing once per accepted bit.
REQ-020 Without QAM_TX_SCRAMBLE_EN, bits SHALL pass unmodified and no LFSR SHALL be built.

Structure
REQ-021 Package qam_pkg SHALL hold the state enum, the preamble and pad symbol constants, and the LFSR seed/taps.
REQ-022 The scrambler SHALL be sub-module qam_lfsr, instantiated only under QAM_TX_SCRAMBLE_EN.

Verification
REQ-023 Reset then start with SYM_DIV=8, PREAMBLE_LEN=2, FRAME_LEN=2, GAP_LEN=1 -> sym_stb every 8 cycles carrying {11,11}, {00,00}, two payload symbols, {01,01}; busy then drops.
REQ-024 Bits 1,0,1,1 fed during PREAMBLE -> first payload symbol sym_i=10, sym_q=11 with underrun 0.
REQ-025 No bits supplied in PAYLOAD -> two {01,01} symbols, each with an underrun pulse.
REQ-026 start during PAYLOAD -> second frame starts directly after GAP with no IDLE cycle.
REQ-027 rst asserted mid-PAYLOAD -> all outputs 0 asynchronously and no sym_stb until the next start.
REQ-028 With QAM_TX_SCRAMBLE_EN defined and input bits all zero -> payload bits equal the LFSR sequence from seed 7'h7F.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared types and constants for the 16QAM transmit symbol scheduler.
// The LFSR constants are only consumed when QAM_TX_SCRAMBLE_EN is defined.
package qam_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        GAP      = 2'd3
    } state_t;

    // Symbols are packed as {sym_i[1:0], sym_q[1:0]}
    localparam logic [3:0] PRE_EVEN_SYM = 4'b1111;
    localparam logic [3:0] PRE_ODD_SYM  = 4'b0000;
    localparam logic [3:0] PAD_SYM      = 4'b0101;

    localparam logic [6:0] LFSR_SEED = 7'h7F;
    localparam logic [6:0] LFSR_TAPS = 7'b110_0000;

endpackage

// File: rtl/qam_lfsr.sv
// x^7+x^6+1 payload scrambler; output is the MSB of the register.
// Instantiated by qam_tx_sched only when QAM_TX_SCRAMBLE_EN is defined.
module qam_lfsr
    import qam_pkg::*;
(
    input  logic clk_carrier,
    input  logic rst,
    input  logic load,
    input  logic advance,
    output logic scr_bit
);

    logic [6:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = LFSR_SEED;
        end else if (advance) begin
            lfsr_d = {lfsr_q[5:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk_carrier or posedge rst) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign scr_bit = lfsr_q[6];

endmodule

// File: rtl/qam_tx_sched.sv
// Frame/symbol scheduler for a 16QAM transmitter: preamble, payload, gap.
// Optional payload scrambling is enabled with the QAM_TX_SCRAMBLE_EN macro.
module qam_tx_sched
    import qam_pkg::*;
#(
    parameter int SYM_DIV      = 200,
    parameter int PREAMBLE_LEN = 8,
    parameter int FRAME_LEN    = 32,
    parameter int GAP_LEN      = 4
) (
    input  logic       clk_carrier,
    input  logic       rst,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [1:0] sym_i,
    output logic [1:0] sym_q,
    output logic       sym_stb,
    output logic [7:0] count_num,
    output logic       busy,
    output logic       underrun
);

    localparam logic [7:0] CNT_LAST   = 8'(SYM_DIV - 1);
    localparam logic [7:0] PRE_LAST   = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] FRAME_LAST = 8'(FRAME_LEN - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] sym_cnt_q, sym_cnt_d;
    logic [3:0] buf_q, buf_d;
    logic [2:0] occ_q, occ_d;
    logic [3:0] symbol_q, symbol_d;
    logic       stb_q, stb_d;
    logic       underrun_q, underrun_d;
    logic       pend_q, pend_d;

    logic tick;
    logic accept;
    logic in_bit;
    logic scr_bit;

    assign tick      = (state_q != IDLE) && (count_q == CNT_LAST);
    assign bit_ready = ((state_q == PREAMBLE) || (state_q == PAYLOAD)) && (occ_q < 3'd4);
    assign accept    = bit_valid && bit_ready;
    assign in_bit    = bit_in ^ scr_bit;

`ifdef QAM_TX_SCRAMBLE_EN
    logic scr_load;
    // Reseed on every entry to PREAMBLE, whether from IDLE or straight from GAP
    assign scr_load = (state_d == PREAMBLE) && (state_q != PREAMBLE);

    qam_lfsr u_lfsr (
        .clk_carrier (clk_carrier),
        .rst         (rst),
        .load        (scr_load),
        .advance     (accept),
        .scr_bit     (scr_bit)
    );
`else
    assign scr_bit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        sym_cnt_d  = sym_cnt_q;
        buf_d      = buf_q;
        occ_d      = occ_q;
        symbol_d   = symbol_q;
        stb_d      = 1'b0;
        underrun_d = 1'b0;
        pend_d     = pend_q;

        if (start && (state_q != IDLE)) begin
            pend_d = 1'b1;
        end

        // Bits fill MSB first: sym_i[1], sym_i[0], sym_q[1], sym_q[0]
        if (accept) begin
            buf_d[2'd3 - occ_q[1:0]] = in_bit;
            occ_d = occ_q + 3'd1;
        end

        if ((state_q == IDLE) || tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = PREAMBLE;
                    sym_cnt_d = '0;
                end
            end
            PREAMBLE: begin
                if (tick) begin
                    stb_d    = 1'b1;
                    symbol_d = sym_cnt_q[0] ? PRE_ODD_SYM : PRE_EVEN_SYM;
                    if (sym_cnt_q == PRE_LAST) begin
                        state_d   = PAYLOAD;
                        sym_cnt_d = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 8'd1;
                    end
                end
            end
            PAYLOAD: begin
                if (tick) begin
                    stb_d = 1'b1;
                    if (occ_q == 3'd4) begin
                        symbol_d = buf_q;
                        occ_d    = accept ? 3'd1 : 3'd0;
                        if (accept) begin
                            buf_d[3] = in_bit;
                        end
                    end else begin
                        // Underrun keeps the partial nibble for the next tick
                        symbol_d   = PAD_SYM;
                        underrun_d = 1'b1;
                    end
                    if (sym_cnt_q == FRAME_LAST) begin
                        state_d   = GAP;
                        sym_cnt_d = '0;
                        occ_d     = '0;
                        buf_d     = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 8'd1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    stb_d    = 1'b1;
                    symbol_d = PAD_SYM;
                    if (sym_cnt_q == GAP_LAST) begin
                        sym_cnt_d = '0;
                        pend_d    = 1'b0;
                        state_d   = (pend_q || start) ? PREAMBLE : IDLE;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_carrier or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            sym_cnt_q  <= '0;
            buf_q      <= '0;
            occ_q      <= '0;
            symbol_q   <= '0;
            stb_q      <= 1'b0;
            underrun_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sym_cnt_q  <= sym_cnt_d;
            buf_q      <= buf_d;
            occ_q      <= occ_d;
            symbol_q   <= symbol_d;
            stb_q      <= stb_d;
            underrun_q <= underrun_d;
            pend_q     <= pend_d;
        end
    end

    assign sym_i     = symbol_q[3:2];
    assign sym_q     = symbol_q[1:0];
    assign sym_stb   = stb_q;
    assign underrun  = underrun_q;
    assign count_num = count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_qam_tx_sched.sv
// Self-checking bench for qam_tx_sched: table of frames plus hand-written
// back-to-back, start-on-last-gap-tick and mid-frame reset sequences.
module tb_qam_tx_sched;

    localparam int SYM_DIV   = 8;
    localparam int PRE_LEN   = 2;
    localparam int FRAME_LEN = 2;
    localparam int GAP_LEN   = 1;

    logic       clk_carrier = 1'b0;
    logic       rst         = 1'b1;
    logic       start       = 1'b0;
    logic       bit_in      = 1'b0;
    logic       bit_valid   = 1'b0;
    logic       bit_ready;
    logic [1:0] sym_i;
    logic [1:0] sym_q;
    logic       sym_stb;
    logic [7:0] count_num;
    logic       busy;
    logic       underrun;

    qam_tx_sched #(
        .SYM_DIV      (SYM_DIV),
        .PREAMBLE_LEN (PRE_LEN),
        .FRAME_LEN    (FRAME_LEN),
        .GAP_LEN      (GAP_LEN)
    ) dut (
        .clk_carrier (clk_carrier),
        .rst         (rst),
        .start       (start),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .sym_i       (sym_i),
        .sym_q       (sym_q),
        .sym_stb     (sym_stb),
        .count_num   (count_num),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 clk_carrier = ~clk_carrier;

    int cyc = 0;
    always @(posedge clk_carrier) cyc++;

    typedef struct {
        logic [7:0] bits;
        int         nbits;
    } vec_t;

    logic [4:0] exp_q[$];
    logic       bit_q[$];
    logic [4:0] mon_exp;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_stb = 0;
    int         last_stb_cyc = 0;
    bit         spc_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference scrambler: x^7+x^6+1, seed 7F, output = MSB, one step per bit
    function automatic logic [7:0] scramble(input logic [7:0] bits, input int n);
        logic [7:0] r;
`ifdef QAM_TX_SCRAMBLE_EN
        logic [6:0] l;
        l = 7'h7F;
`endif
        r = bits;
        for (int i = 0; i < n; i++) begin
`ifdef QAM_TX_SCRAMBLE_EN
            r[7-i] = bits[7-i] ^ l[6];
            l = {l[5:0], l[6] ^ l[5]};
`endif
        end
        return r;
    endfunction

    task automatic queue_frame(input logic [7:0] bits, input int nbits);
        logic [7:0] sb;
        sb = scramble(bits, nbits);
        exp_q.push_back({4'b1111, 1'b0});
        exp_q.push_back({4'b0000, 1'b0});
        for (int j = 0; j < FRAME_LEN; j++) begin
            if (nbits >= 4 * (j + 1)) exp_q.push_back({sb[7-4*j -: 4], 1'b0});
            else                      exp_q.push_back({4'b0101, 1'b1});
        end
        for (int g = 0; g < GAP_LEN; g++) exp_q.push_back({4'b0101, 1'b0});
        for (int i = 0; i < nbits; i++) bit_q.push_back(bits[7-i]);
    endtask

    task automatic pulse_start(input bit fresh, input bit chk);
        @(negedge clk_carrier) start = 1'b1;
        @(posedge clk_carrier);
        #1;
        if (fresh) begin
            last_stb_cyc = cyc;
            spc_en = 1'b1;
        end
        @(negedge clk_carrier) start = 1'b0;
        if (chk) begin
            check("count_after_entry", 32'(count_num), 0);
            check("busy_after_start", 32'(busy), 1);
            @(negedge clk_carrier);
            check("count_second_cycle", 32'(count_num), 1);
        end
    endtask

    task automatic wait_stb(input int target, input int max, output bit busy_low);
        bit done;
        done = 1'b0;
        busy_low = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_carrier);
            #1;
            if (n_stb >= target) begin
                done = 1'b1;
                break;
            end
            if (!busy) busy_low = 1'b1;
        end
        check("stb_count_reached", 32'(done), 1);
    endtask

    task automatic wait_idle(input int max);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_carrier);
            #1;
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_reached", 32'(done), 1);
        @(negedge clk_carrier);
        #1;
        check("exp_drained", 32'(exp_q.size()), 0);
        check("bits_drained", 32'(bit_q.size()), 0);
        spc_en = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk_carrier) begin
        if (!rst) begin
            check("underrun_implies_stb", 32'(underrun & ~sym_stb), 0);
            if (sym_stb) begin
                n_stb++;
                if (exp_q.size() == 0) begin
                    check("unexpected_stb_queue_size", 32'(exp_q.size()), 1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("symbol_i_q_underrun", 32'({sym_i, sym_q, underrun}), 32'(mon_exp));
                end
                if (spc_en) check("stb_spacing", 32'(cyc - last_stb_cyc), SYM_DIV);
                last_stb_cyc = cyc;
            end
        end
    end

    // Bit source: bit_ready is flop-driven, so its negedge value holds at the next posedge
    initial begin
        forever begin
            @(negedge clk_carrier);
            if (!rst && bit_q.size() > 0) begin
                bit_valid = 1'b1;
                bit_in    = bit_q[0];
                if (bit_ready) void'(bit_q.pop_front());
            end else begin
                bit_valid = 1'b0;
                bit_in    = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   base;
        bit   blow;

        vecs[0] = '{8'b1011_0110, 8};
        vecs[1] = '{8'b0000_0000, 0};
        vecs[2] = '{8'b1100_0000, 4};
        vecs[3] = '{8'b1110_0000, 2};
        vecs[4] = '{8'b0101_1001, 8};
        vecs[5] = '{8'b0001_1111, 7};
        vecs[6] = '{8'b1000_0001, 8};

        rst = 1'b1;
        repeat (3) @(negedge clk_carrier);
        check("rst_sym_stb", 32'(sym_stb), 0);
        check("rst_sym_iq", 32'({sym_i, sym_q}), 0);
        check("rst_count", 32'(count_num), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_bit_ready", 32'(bit_ready), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk_carrier);
        check("idle_count", 32'(count_num), 0);
        check("idle_busy", 32'(busy), 0);

        for (int i = 0; i < 7; i++) begin
            queue_frame(vecs[i].bits, vecs[i].nbits);
            pulse_start(1'b1, i == 0);
            wait_idle(200);
        end

        // Two starts during PAYLOAD collapse into one extra back-to-back frame
        queue_frame(8'h3C, 8);
        queue_frame(8'hD2, 8);
        base = n_stb;
        pulse_start(1'b1, 1'b0);
        wait_stb(base + 3, 100, blow);
        pulse_start(1'b0, 1'b0);
        pulse_start(1'b0, 1'b0);
        wait_stb(base + 10, 200, blow);
        check("b2b_no_idle_between", 32'(blow), 0);
        repeat (30) @(negedge clk_carrier);
        #1;
        check("b2b_collapsed_stb_count", 32'(n_stb - base), 10);
        check("b2b_busy_end", 32'(busy), 0);
        check("b2b_exp_drained", 32'(exp_q.size()), 0);
        spc_en = 1'b0;

        // start coincident with the final GAP tick
        queue_frame(8'h96, 8);
        queue_frame(8'h4B, 6);
        base = n_stb;
        pulse_start(1'b1, 1'b0);
        wait_stb(base + 4, 100, blow);
        repeat (7) @(negedge clk_carrier);
        start = 1'b1;
        @(negedge clk_carrier);
        start = 1'b0;
        wait_stb(base + 10, 200, blow);
        check("gap_tick_start_no_idle", 32'(blow), 0);
        repeat (20) @(negedge clk_carrier);
        #1;
        check("gap_tick_stb_count", 32'(n_stb - base), 10);
        check("gap_tick_exp_drained", 32'(exp_q.size()), 0);
        spc_en = 1'b0;

        // Asynchronous reset in the middle of PAYLOAD
        queue_frame(8'hE7, 8);
        base = n_stb;
        pulse_start(1'b1, 1'b0);
        wait_stb(base + 3, 100, blow);
        repeat (3) @(posedge clk_carrier);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_count", 32'(count_num), 0);
        check("arst_sym_iq", 32'({sym_i, sym_q}), 0);
        check("arst_stb_underrun", 32'({sym_stb, underrun}), 0);
        check("arst_bit_ready", 32'(bit_ready), 0);
        exp_q.delete();
        bit_q.delete();
        spc_en = 1'b0;
        repeat (2) @(negedge clk_carrier);
        rst = 1'b0;
        base = n_stb;
        repeat (40) @(negedge clk_carrier);
        #1;
        check("no_stb_after_reset", 32'(n_stb - base), 0);
        check("idle_after_reset", 32'(busy), 0);

        queue_frame(8'hA5, 8);
        pulse_start(1'b1, 1'b1);
        wait_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
